// File: rtl/imersiv_net_sequencer_if.sv
// Bus bundle for imersiv_net_sequencer.
//   start         : one-cycle pulse from the image buffer (last row written)
//   image_in      : 28 image rows, bits [27:0] used, bit 27 = leftmost pixel
//   w_addr        : registered weight ROM address
//   w_data        : signed 8-bit ROM word, valid one cycle after w_addr
//   irq_clr       : pulse on a bus read of the character register
//   busy          : run in progress (cycle after start through done)
//   done          : one-cycle pulse when character_reg updates
//   character_reg : zero-extended winning class index
//   character_irq : level interrupt, set on done, cleared by irq_clr
// The slave modport is the sequencer; the master modport is its environment.
interface imersiv_net_sequencer_if #(
    parameter int W_AW = 15
);
    logic              start;
    logic [31:0]       image_in [28];
    logic [W_AW-1:0]   w_addr;
    logic signed [7:0] w_data;
    logic              irq_clr;
    logic              busy;
    logic              done;
    logic [31:0]       character_reg;
    logic              character_irq;

    modport master (
        output start, image_in, w_data, irq_clr,
        input  w_addr, busy, done, character_reg, character_irq
    );

    modport slave (
        input  start, image_in, w_data, irq_clr,
        output w_addr, busy, done, character_reg, character_irq
    );
endinterface

// File: rtl/imersiv_net_sequencer.sv
// Control-and-accumulate engine for the Imersiv Net inference path.
// On start it snapshots the 28x28 binary image, walks the synchronous weight
// ROM through the hidden layer (784 weights + bias per neuron, ReLU, clamp to
// 15 bits) and the output layer (N_HID weights + bias per class), picks the
// argmax class (ties keep the lowest index) and raises the character IRQ.
// Ports:
//   clk : clock, all state on the rising edge
//   rst : asynchronous, active-high reset
//   bus : imersiv_net_sequencer_if slave modport (see interface header)
module imersiv_net_sequencer #(
    parameter int N_HID = 32,
    parameter int N_OUT = 16,
    parameter int W_AW  = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    imersiv_net_sequencer_if.slave        bus
);

    localparam int N_PIX = 784;
    localparam int KW    = 10;
    localparam int JW    = $clog2(N_HID + 1);
    localparam int HW    = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_L1,
        S_L1_WB,
        S_L2,
        S_L2_WB,
        S_FIN
    } state_t;

    state_t             state;
    state_t             state_nx;

    logic [KW-1:0]      k_cnt;      // issue index within a hidden neuron
    logic [JW-1:0]      j_cnt;      // issue index within an output neuron
    logic [HW-1:0]      n_cnt;      // hidden neuron
    logic [OW-1:0]      m_cnt;      // output neuron
    logic [W_AW-1:0]    w_addr;
    logic signed [19:0] acc1;
    logic signed [31:0] acc2;
    logic signed [31:0] best_val;
    logic [OW-1:0]      best_idx;
    logic               pix_d;      // pixel matching the word returning next cycle
    logic [31:0]        char_reg;
    logic               irq;

    logic [N_PIX-1:0]   snap;
    logic [15:0]        hid_buf [N_HID];

    logic signed [19:0] w_ext1;
    logic signed [19:0] l1_sum;
    logic [15:0]        relu_val;
    logic signed [31:0] w_ext2;
    logic signed [31:0] h_ext;
    logic signed [31:0] prod;
    logic signed [31:0] l2_sum;
    logic [HW-1:0]      hid_idx;
    logic               k_end;
    logic               j_end;
    logic               n_last;
    logic               m_last;

    assign k_end  = (k_cnt == KW'(N_PIX));
    assign j_end  = (j_cnt == JW'(N_HID));
    assign n_last = (n_cnt == HW'(N_HID - 1));
    assign m_last = (m_cnt == OW'(N_OUT - 1));

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    // NOTE: the default assignment first means no path leaves state_nx
    // unassigned, so no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.start) state_nx = S_L1;
            S_L1:    if (k_end)     state_nx = S_L1_WB;
            S_L1_WB: state_nx = n_last ? S_L2 : S_L1;
            S_L2:    if (j_end)     state_nx = S_L2_WB;
            S_L2_WB: state_nx = m_last ? S_FIN : S_L2;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Arithmetic on the word returning from the ROM this cycle
    // ------------------------------------------------------------------
    always_comb begin
        w_ext1   = {{12{bus.w_data[7]}}, bus.w_data};
        w_ext2   = {{24{bus.w_data[7]}}, bus.w_data};
        l1_sum   = acc1 + w_ext1;
        relu_val = '0;
        if (!l1_sum[19]) begin
            relu_val = (l1_sum > 20'sd32767) ? 16'h7FFF : l1_sum[15:0];
        end
        // Word returning at issue index j belongs to hidden value j-1.
        hid_idx  = HW'(j_cnt - JW'(1));
        h_ext    = {16'b0, hid_buf[hid_idx]};
        prod     = h_ext * w_ext2;
        l2_sum   = acc2 + w_ext2;
    end

    // ------------------------------------------------------------------
    // Datapath, counters, address generator and result registers
    // ------------------------------------------------------------------
    // The ROM address space is contiguous across neurons and layers, so the
    // address simply increments, pausing for the write-back cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_addr   <= '0;
            k_cnt    <= '0;
            j_cnt    <= '0;
            n_cnt    <= '0;
            m_cnt    <= '0;
            acc1     <= '0;
            acc2     <= '0;
            best_val <= '0;
            best_idx <= '0;
            pix_d    <= 1'b0;
            char_reg <= '0;
            irq      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        w_addr <= '0;
                        k_cnt  <= '0;
                        j_cnt  <= '0;
                        n_cnt  <= '0;
                        m_cnt  <= '0;
                        acc1   <= '0;
                        acc2   <= '0;
                    end
                end
                S_L1: begin
                    if (k_cnt != '0 && pix_d) begin
                        acc1 <= l1_sum;
                    end
                    if (!k_end) begin
                        pix_d  <= snap[KW'(N_PIX - 1) - k_cnt];
                        w_addr <= w_addr + W_AW'(1);
                        k_cnt  <= k_cnt + KW'(1);
                    end
                end
                S_L1_WB: begin
                    // The bias word is always added.
                    acc1   <= '0;
                    k_cnt  <= '0;
                    j_cnt  <= '0;
                    n_cnt  <= n_cnt + HW'(1);
                    w_addr <= w_addr + W_AW'(1);
                end
                S_L2: begin
                    if (j_cnt != '0) begin
                        acc2 <= acc2 + prod;
                    end
                    if (!j_end) begin
                        w_addr <= w_addr + W_AW'(1);
                        j_cnt  <= j_cnt + JW'(1);
                    end
                end
                S_L2_WB: begin
                    // Strict compare keeps the lowest index on ties.
                    if (m_cnt == '0 || l2_sum > best_val) begin
                        best_val <= l2_sum;
                        best_idx <= m_cnt;
                    end
                    acc2  <= '0;
                    j_cnt <= '0;
                    m_cnt <= m_cnt + OW'(1);
                    if (!m_last) begin
                        w_addr <= w_addr + W_AW'(1);
                    end
                end
                S_FIN: begin
                    char_reg <= 32'(best_idx);
                end
                default: ;
            endcase

            // Setting on FIN takes priority over a coincident clear.
            if (state == S_FIN) begin
                irq <= 1'b1;
            end else if (bus.irq_clr) begin
                irq <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Image snapshot and hidden-value buffer
    // ------------------------------------------------------------------
    // NOTE: these storage arrays have no reset; every run rewrites them
    // before they are read, so clearing them would only cost logic.
    // Row r, bit b lands at (27-r)*28+b, so pixel k sits at bit 783-k.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.start) begin
            for (int r = 0; r < 28; r++) begin
                snap[(27 - r) * 28 +: 28] <= bus.image_in[r][27:0];
            end
        end
        if (state == S_L1_WB) begin
            hid_buf[n_cnt] <= relu_val;
        end
    end

    assign bus.w_addr        = w_addr;
    assign bus.busy          = (state != S_IDLE);
    assign bus.done          = (state == S_FIN);
    assign bus.character_reg = char_reg;
    assign bus.character_irq = irq;

endmodule

// File: tb/tb_imersiv_net_sequencer.sv
// Self-checking bench for imersiv_net_sequencer: a ROM model, directed runs,
// and a scoreboard whose monitor checks each DONE against queued expectations.
module tb_imersiv_net_sequencer;

    localparam int N_HID   = 32;
    localparam int N_OUT   = 16;
    localparam int W_AW    = 15;
    localparam int L2_BASE = 25120;  // 32*785
    localparam int T_DONE  = 25697;  // 1 + 32*786 + 16*34

    typedef struct {
        int          done_cyc;
        logic [31:0] char_val;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    int   start_cyc;
    logic mon_active;
    exp_t sb [$];

    logic signed [7:0] rom [0:(1 << W_AW) - 1];

    imersiv_net_sequencer_if #(.W_AW(W_AW)) bus ();

    imersiv_net_sequencer #(
        .N_HID (N_HID),
        .N_OUT (N_OUT),
        .W_AW  (W_AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM, one-cycle latency.
    always @(posedge clk) bus.w_data <= rom[bus.w_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every DONE pops one expectation.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            exp_t e;
            mon_active = 1'b1;
            if (sb.size() == 0) begin
                check("done_unexpected", 32'(bus.done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                @(negedge clk);
                check("character_reg", bus.character_reg, e.char_val);
                check("character_irq_set", 32'(bus.character_irq), 32'd1);
                check("busy_after_done", 32'(bus.busy), 32'd0);
            end
            mon_active = 1'b0;
        end
    end

    function automatic int ob(input int m);
        return L2_BASE + m * (N_HID + 1);
    endfunction

    task automatic set_image_blank();
        // Unused upper bits are set to show they are ignored.
        for (int r = 0; r < 28; r++) bus.image_in[r] = 32'hF000_0000;
    endtask

    task automatic set_image_pixel00();
        for (int r = 0; r < 28; r++) bus.image_in[r] = 32'h0;
        bus.image_in[0] = 32'h0800_0000;
    endtask

    task automatic issue_start(input logic [31:0] exp_char);
        exp_t e;
        @(negedge clk);
        bus.start  = 1'b1;
        start_cyc  = cyc;
        e.done_cyc = cyc + T_DONE;
        e.char_val = exp_char;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_scoreboard_empty();
        int n;
        n = 0;
        while ((sb.size() != 0 || mon_active) && n < 30000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30000) begin
            check("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        cyc         = 0;
        checks      = 0;
        failures    = 0;
        mon_active  = 1'b0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.irq_clr = 1'b0;
        set_image_blank();
        for (int i = 0; i < (1 << W_AW); i++) rom[i] = 8'sd0;

        // hidden0 k0 = +10, hidden1 bias = -5, hidden2 k0 = +10
        rom[0 * 785 + 0]   = 8'sd10;
        rom[1 * 785 + 784] = -8'sd5;
        rom[2 * 785 + 0]   = 8'sd10;
        // out5 bias = 3; out12 and out14 read hidden0/hidden2 with weight 2
        rom[ob(5) + N_HID] = 8'sd3;
        rom[ob(12) + 0]    = 8'sd2;
        rom[ob(12) + 2]    = 8'sd2;
        rom[ob(14) + 0]    = 8'sd2;
        rom[ob(14) + 2]    = 8'sd2;
        // out3 / out4 read hidden1, which ReLU must force to 0
        rom[ob(3) + 1]     = -8'sd1;
        rom[ob(4) + 1]     = 8'sd1;

        repeat (2) @(negedge clk);
        check("rst_w_addr", 32'(bus.w_addr), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_character_reg", bus.character_reg, 32'd0);
        check("rst_character_irq", 32'(bus.character_irq), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Run 1: blank image -> all hidden 0, out5=3 wins. A second START
        // with a new image at +100 and a full rewrite at +200 must be ignored.
        issue_start(32'd5);
        wait_until(start_cyc + 100);
        set_image_pixel00();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_until(start_cyc + 200);
        for (int r = 0; r < 28; r++) bus.image_in[r] = 32'h0FFF_FFFF;
        wait_scoreboard_empty();

        // Run 2: aborted by reset at +5000.
        set_image_pixel00();
        issue_start(32'd12);
        wait_until(start_cyc + 5000);
        rst = 1'b1;
        #1;
        check("midrun_rst_w_addr", 32'(bus.w_addr), 32'd0);
        check("midrun_rst_busy", 32'(bus.busy), 32'd0);
        check("midrun_rst_done", 32'(bus.done), 32'd0);
        check("midrun_rst_character_reg", bus.character_reg, 32'd0);
        check("midrun_rst_character_irq", 32'(bus.character_irq), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Run 3: pixel (0,0) -> hidden0=hidden2=10, out12=out14=40, tie -> 12.
        // IRQ_CLR coincides with FIN; the set must win.
        issue_start(32'd12);
        wait_until(start_cyc + T_DONE);
        bus.irq_clr = 1'b1;
        @(negedge clk);
        bus.irq_clr = 1'b0;
        wait_scoreboard_empty();

        // Plain IRQ_CLR clears the interrupt on the next cycle.
        @(negedge clk);
        bus.irq_clr = 1'b1;
        @(negedge clk);
        bus.irq_clr = 1'b0;
        check("irq_cleared", 32'(bus.character_irq), 32'd0);
        check("character_reg_held", bus.character_reg, 32'd12);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imersiv_net_sequencer.md
# imersiv_net_sequencer

Control-and-accumulate engine for the Imersiv Net inference path. It sits between the 28x28 image buffer and the character register. On START it snapshots the image and walks a synchronous weight ROM through the hidden layer and the output layer, accumulating each neuron. It then selects the winning class by argmax and raises the character IRQ. It is the only block that sequences the ROM, the hidden-value buffer and the accumulator.

## Interface
- N_HID, 32: hidden-layer neurons.
- N_OUT, 16: output classes (0-9 [ ] + - * / = indices 0..15).
- W_AW, 15: weight ROM address width; must cover N_HID*785 + N_OUT*(N_HID+1) words.

- CLK  in  1  clock, all state on rising edge.
- RESET  in  1  reset; asynchronous, active-high.
- START  in  1  one-cycle pulse from image buffer (write of last row).
- IMAGE_IN  in  28x32 (unpacked)  image rows. Bits [27:0] are used, bit 27 = leftmost pixel.
- W_ADDR  out  W_AW  weight ROM address, registered.
- W_DATA  in  8  signed weight/bias, valid one cycle after W_ADDR.
- IRQ_CLR  in  1  pulse on bus read of the character register.
- BUSY  out  1  high from the cycle after START accepted through the DONE cycle.
- DONE  out  1  one-cycle pulse when CHARACTER_REG updates.
- CHARACTER_REG  out  32  zero-extended winning class index [3:0].
- CHARACTER_IRQ  out  1  level IRQ, set on DONE, cleared by IRQ_CLR.

## Operation
- States: IDLE, L1, L1_WB, L2, L2_WB, FIN.
- IDLE + START: latch IMAGE_IN[27:0] of all 28 rows into an internal 784-bit snapshot. Clear counters; go to L1. Later image writes do not affect the run.
- Pixel k (0..783) = snapshot row k/28, bit 27-(k mod 28).
- ROM layout:
  - Hidden neuron n: weights at n*785+k, bias at n*785+784.
  - L2_BASE = N_HID*785.
  - Output neuron m: weights at L2_BASE+m*(N_HID+1)+j, bias at L2_BASE+m*(N_HID+1)+N_HID.
- L1: issue one address per cycle, 785 cycles per neuron (784 weights, then bias). The returned weight is added when its delayed pixel bit is 1. The bias is always added, sign-extended.
- L1_WB: add the final returned word. Apply ReLU, clamp to [0, 32767], write the 16-bit hidden buffer entry n, clear the accumulator. Next neuron goes to L1, or after n = N_HID-1 go to L2.
- L2: N_HID+1 issue cycles per output neuron. Accumulate h_j * W_DATA (16-bit unsigned x 8-bit signed), then add the bias.
- L2_WB: final add, then compare. Replace best_val/best_idx only when acc > best_val (strict). Ties therefore keep the lowest index. Neuron 0 always loads best.
- FIN: CHARACTER_REG <= {28'b0, best_idx}; DONE=1; CHARACTER_IRQ <= 1. Return to IDLE.
- Arithmetic:
  - L1 accumulator 20-bit signed (cannot overflow for 785 terms).
  - L2 accumulator 32-bit signed, wraps (no saturation).
- START while not IDLE: ignored, no effect on the snapshot.
- IRQ_CLR and FIN in the same cycle: the IRQ is set (set wins).
- RESET asserted anytime, including mid-run:
  - immediately state=IDLE, W_ADDR=0, BUSY=0, DONE=0, CHARACTER_REG=0, CHARACTER_IRQ=0, accumulators and counters 0.
  - The hidden buffer and snapshot need not be cleared.

## Timing
- Cycle 0 = cycle START is sampled high in IDLE. L1 starts at cycle 1 with W_ADDR=0.
- Per hidden neuron: 786 cycles (785 issue + 1 WB). Per output neuron: N_HID+2 cycles.
- DONE at cycle T = 1 + N_HID*786 + N_OUT*(N_HID+2). With defaults T = 25697.
- W_ADDR holds its last value outside L1/L2. ROM read latency is exactly 1 cycle; no stall input.
- Next START is accepted at cycle T+1 at the earliest.

## Test plan
- All weights/biases 0, blank image, START -> DONE at cycle 25697, CHARACTER_REG=0 (tie to lowest index), CHARACTER_IRQ=1, BUSY low at T+1.
- Output bias for m=5 equals 3, all else 0 -> CHARACTER_REG=5. Then pulse IRQ_CLR -> CHARACTER_IRQ=0 next cycle.
- Pixel (row 0, col 0) set, hidden n=0 weight k=0 = +10, output m=12 weight j=0 = +2, all else 0 -> hidden0=10, out12=20, CHARACTER_REG=12.
- Hidden bias of n=0 = -5, blank image, output m=3 weight j=0 = -1, all else 0 -> ReLU gives hidden0=0, all outputs 0, CHARACTER_REG=0 (not 3).
- Second START at cycle 100 and image rewrite at cycle 200 of a run -> ignored. DONE still at 25697 with the result of the original snapshot.
- RESET asserted at cycle 5000 -> all outputs 0 immediately. A fresh START completes normally in 25697 cycles. IRQ_CLR coincident with FIN leaves CHARACTER_IRQ=1.
